// File: rtl/fifo_rd_arb_ctrl.sv
// fifo_rd_arb_ctrl
//   Read-domain half of the async FIFO. It takes the synchronised Gray write
//   pointer, owns the read pointer (binary and Gray), derives the empty flag
//   and fill level, and shares the single RAM read port among NREQ consumers.
//   Sharing is round-robin, and a requester that keeps its request high may
//   hold the port for up to BURST consecutive grants.
//
// Ports
//   rd_clk      read-domain clock
//   rd_rst      asynchronous, active-high reset
//   rq2_wr_ptr  synchronised Gray write pointer (ADDR_W+1 bits)
//   req         per-consumer read request, level sensitive
//   grant       one-hot grant, combinational; the pop happens in this cycle
//   rd_en       RAM read enable (= |grant)
//   rd_addr     RAM read address (low ADDR_W bits of the binary read pointer)
//   rd_ptr      registered Gray read pointer, sent to the r2w synchroniser
//   rd_empty    registered empty flag
//   rd_level    registered count of entries available (pessimistic)
//   rd_valid    RAM data valid, one cycle after grant
//   rd_owner    index of the consumer that receives the current data
module fifo_rd_arb_ctrl #(
  parameter int ADDR_W = 5,
  parameter int NREQ   = 4,
  parameter int BURST  = 4
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic [ADDR_W:0]          rq2_wr_ptr,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          grant,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [ADDR_W:0]          rd_ptr,
  output logic                     rd_empty,
  output logic [ADDR_W:0]          rd_level,
  output logic                     rd_valid,
  output logic [$clog2(NREQ)-1:0]  rd_owner
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(BURST + 1);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    int m;
    m = v % NREQ;
    return m[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NREQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  logic [ADDR_W:0]   rbin;
  logic [ADDR_W:0]   rbin_next;
  logic [ADDR_W:0]   wr_bin;
  logic [IDX_W-1:0]  prio;       // search start index
  logic [IDX_W-1:0]  last;       // most recent grant winner
  logic [CNT_W-1:0]  burst_cnt;  // grants given to 'last' in its current burst
  logic [CNT_W-1:0]  cnt_new;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  cand;
  logic              found;

  // Round-robin search from prio. No grant while empty or in reset, so the
  // last entry is never popped twice.
  // NOTE: every variable gets a default at the top of always_comb; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    grant = '0;
    win   = prio;
    cand  = '0;
    found = 1'b0;
    if (!rd_rst && !rd_empty) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = wrap_idx(int'(prio) + k);
        if (!found && req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
    if (found) grant[win] = 1'b1;
  end

  assign rd_en     = found;
  assign rd_addr   = rbin[ADDR_W-1:0];
  assign rbin_next = rbin + {{ADDR_W{1'b0}}, rd_en};
  assign wr_bin    = gray2bin(rq2_wr_ptr);

  // A win by the current owner extends its burst; any other win starts a
  // new burst of one. A burst that restarts after exhaustion also counts
  // from one.
  assign cnt_new = (win == last && burst_cnt < CNT_W'(BURST)) ?
                   burst_cnt + CNT_W'(1) : CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rbin      <= '0;
      rd_ptr    <= '0;
      rd_empty  <= 1'b1;
      rd_level  <= '0;
      rd_valid  <= 1'b0;
      rd_owner  <= '0;
      burst_cnt <= '0;
      last      <= '0;
      prio      <= '0;
    end else begin
      rbin     <= rbin_next;
      rd_ptr   <= bin2gray(rbin_next);
      // Full Gray compare including the wrap bit: equal addresses with a
      // different wrap bit mean full, not empty.
      rd_empty <= (bin2gray(rbin_next) == rq2_wr_ptr);
      rd_level <= wr_bin - rbin_next;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_owner  <= win;
        last      <= win;
        burst_cnt <= cnt_new;
        prio      <= (cnt_new == CNT_W'(BURST)) ? next_idx(win) : win;
      end else if (!req[last] && prio == last) begin
        // Owner released its request: end the burst and move past it.
        prio      <= next_idx(last);
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_arb_ctrl.sv
// Self-checking bench for fifo_rd_arb_ctrl. Two instances share all inputs:
// index 0 uses BURST=4 and index 1 uses BURST=1. A behavioural model tracks
// the FIFO occupancy as plain integers. It tracks each arbiter as an owner
// and a count of grants that owner has used in its current burst.
module tb_fifo_rd_arb_ctrl;
  localparam int AW = 5;
  localparam int NR = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic [AW:0]   wb = '0;
  logic [AW:0]   rq2;
  logic [NR-1:0] req = '0;

  logic [NR-1:0] grant_o [2];
  logic          rd_en_o [2];
  logic [AW-1:0] addr_o  [2];
  logic [AW:0]   ptr_o   [2];
  logic          empty_o [2];
  logic [AW:0]   lvl_o   [2];
  logic          valid_o [2];
  logic [1:0]    owner_o [2];

  assign rq2 = wb ^ (wb >> 1);
  always #5 rd_clk = ~rd_clk;

  fifo_rd_arb_ctrl #(.ADDR_W(AW), .NREQ(NR), .BURST(4)) u_b4 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rq2_wr_ptr(rq2), .req(req),
    .grant(grant_o[0]), .rd_en(rd_en_o[0]), .rd_addr(addr_o[0]), .rd_ptr(ptr_o[0]),
    .rd_empty(empty_o[0]), .rd_level(lvl_o[0]), .rd_valid(valid_o[0]), .rd_owner(owner_o[0]));

  fifo_rd_arb_ctrl #(.ADDR_W(AW), .NREQ(NR), .BURST(1)) u_b1 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rq2_wr_ptr(rq2), .req(req),
    .grant(grant_o[1]), .rd_en(rd_en_o[1]), .rd_addr(addr_o[1]), .rd_ptr(ptr_o[1]),
    .rd_empty(empty_o[1]), .rd_level(lvl_o[1]), .rd_valid(valid_o[1]), .rd_owner(owner_o[1]));

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int m_rbin;
  bit m_empty;
  int m_level;
  int own  [2];
  int used [2];
  bit vout [2];
  int oout [2];
  int pg   [2];

  function automatic int burst_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [AW:0] gray(int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  // The owner keeps the port while it requests and has burst budget left;
  // otherwise the search begins just after it.
  function automatic int pick(int i);
    int start;
    if (rd_rst || m_empty || req == '0) return -1;
    start = (req[own[i]] && used[i] < burst_of(i)) ? own[i] : (own[i] + 1) % NR;
    for (int k = 0; k < NR; k++)
      if (req[(start + k) % NR]) return (start + k) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    m_rbin  = 0;
    m_empty = 1'b1;
    m_level = 0;
    for (int i = 0; i < 2; i++) begin
      own[i] = 0; used[i] = 0; vout[i] = 1'b0; oout[i] = 0; pg[i] = -1;
    end
  endtask

  task automatic model_update();
    if (rd_rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (pg[i] >= 0) begin
        if (pg[i] == own[i] && used[i] < burst_of(i)) used[i]++;
        else begin own[i] = pg[i]; used[i] = 1; end
        vout[i] = 1'b1;
        oout[i] = pg[i];
      end else begin
        vout[i] = 1'b0;
        if (!req[own[i]]) used[i] = burst_of(i);
      end
    end
    if (pg[0] >= 0) m_rbin = (m_rbin + 1) % 64;
    m_empty = (m_rbin == int'(wb));
    m_level = (int'(wb) - m_rbin + 64) % 64;
  endtask

  function automatic logic [25:0] obs(int i);
    return {grant_o[i], rd_en_o[i], addr_o[i], ptr_o[i], empty_o[i], lvl_o[i], valid_o[i], owner_o[i]};
  endfunction

  function automatic logic [25:0] expv(int i);
    logic [NR-1:0] g;
    logic [31:0]   r, l, o;
    g = (pg[i] >= 0) ? NR'(1 << pg[i]) : '0;
    r = m_rbin; l = m_level; o = oout[i];
    return {g, pg[i] >= 0, r[AW-1:0], gray(m_rbin), m_empty, l[AW:0], vout[i], o[1:0]};
  endfunction

  task automatic prep();
    @(negedge rd_clk);
    for (int i = 0; i < 2; i++) pg[i] = pick(i);
  endtask

  task automatic commit();
    @(posedge rd_clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rd_rst = 1'b1; wb = '0; req = '0;
    model_reset();
    repeat (2) @(posedge rd_clk);
    #1 rd_rst = 1'b0;
  endtask

  task automatic test_reset();
    rd_rst = 1'b1; wb = '0; req = 4'b1111;
    model_reset();
    repeat (2) @(posedge rd_clk);
    prep();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({grant_o[i], empty_o[i], ptr_o[i], lvl_o[i], valid_o[i]} !== {4'b0000, 1'b1, 6'd0, 6'd0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_const[%0d] got=%h want=%h", i,
                 {grant_o[i], empty_o[i], ptr_o[i], lvl_o[i], valid_o[i]}, {4'b0000, 1'b1, 6'd0, 6'd0, 1'b0});
      end
      n_cmp++;
      if (obs(i) !== expv(i)) begin
        n_err++; $display("FAIL reset_model[%0d] got=%h want=%h", i, obs(i), expv(i));
      end
    end
    @(posedge rd_clk); #1 rd_rst = 1'b0;
    prep();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== expv(i)) begin
        n_err++; $display("FAIL reset_release[%0d] got=%h want=%h", i, obs(i), expv(i));
      end
    end
    commit();
  endtask

  task automatic test_single_pop();
    do_reset();
    wb = 6'd1; req = 4'b0100;
    prep();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== expv(i)) begin
        n_err++; $display("FAIL pop_wait[%0d] got=%h want=%h", i, obs(i), expv(i));
      end
    end
    commit();
    prep();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({grant_o[i], addr_o[i]} !== {4'b0100, 5'd0}) begin
        n_err++; $display("FAIL pop_grant[%0d] got=%h want=%h", i, {grant_o[i], addr_o[i]}, {4'b0100, 5'd0});
      end
    end
    commit();
    req = '0;
    prep();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({ptr_o[i], empty_o[i], valid_o[i], owner_o[i]} !== {6'b000001, 1'b1, 1'b1, 2'd2}) begin
        n_err++;
        $display("FAIL pop_after[%0d] got=%h want=%h", i,
                 {ptr_o[i], empty_o[i], valid_o[i], owner_o[i]}, {6'b000001, 1'b1, 1'b1, 2'd2});
      end
      n_cmp++;
      if (obs(i) !== expv(i)) begin
        n_err++; $display("FAIL pop_model[%0d] got=%h want=%h", i, obs(i), expv(i));
      end
    end
    commit();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] want [2];
    do_reset();
    wb = 6'd8; req = 4'b1111;
    prep(); commit();
    for (int k = 0; k < 9; k++) begin
      prep();
      want[0] = (k < 8) ? NR'(1 << (k / 4)) : '0;
      want[1] = (k < 8) ? NR'(1 << (k % 4)) : '0;
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (grant_o[i] !== want[i]) begin
          n_err++; $display("FAIL rr_seq[%0d] k=%0d got=%b want=%b", i, k, grant_o[i], want[i]);
        end
        n_cmp++;
        if (obs(i) !== expv(i)) begin
          n_err++; $display("FAIL rr_model[%0d] k=%0d got=%h want=%h", i, k, obs(i), expv(i));
        end
      end
      commit();
    end
  endtask

  task automatic test_burst();
    int seq [10] = '{0, 0, 0, 0, 3, 3, 3, 3, 0, 0};
    logic [NR-1:0] want;
    do_reset();
    wb = 6'd10; req = 4'b1001;
    prep(); commit();
    for (int k = 0; k < 10; k++) begin
      prep();
      want = NR'(1 << seq[k]);
      n_cmp++;
      if (grant_o[0] !== want) begin
        n_err++; $display("FAIL burst_seq k=%0d got=%b want=%b", k, grant_o[0], want);
      end
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== expv(i)) begin
          n_err++; $display("FAIL burst_model[%0d] k=%0d got=%h want=%h", i, k, obs(i), expv(i));
        end
      end
      commit();
    end
    // Owner drops mid-burst: the other requester wins in the same cycle.
    do_reset();
    wb = 6'd10; req = 4'b1001;
    prep(); commit();
    prep(); commit();
    prep(); commit();
    req = 4'b1000;
    prep();
    n_cmp++;
    if (grant_o[0] !== 4'b1000) begin
      n_err++; $display("FAIL burst_drop got=%b want=%b", grant_o[0], 4'b1000);
    end
    commit();
    req = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      prep();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== expv(i)) begin
          n_err++; $display("FAIL drop_model[%0d] k=%0d got=%h want=%h", i, k, obs(i), expv(i));
        end
      end
      commit();
    end
  endtask

  task automatic test_wrap();
    int pushes = 0;
    do_reset();
    for (int c = 0; c < 260; c++) begin
      req = NR'($urandom_range(1, 15));
      prep();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== expv(i)) begin
          n_err++; $display("FAIL wrap_model[%0d] c=%0d got=%h want=%h", i, c, obs(i), expv(i));
        end
        n_cmp++;
        if (lvl_o[i] > 6'd32) begin
          n_err++; $display("FAIL wrap_level[%0d] got=%0d want<=32", i, lvl_o[i]);
        end
      end
      if (m_rbin == 63) begin
        n_cmp++;
        if (ptr_o[0] !== 6'b100000) begin
          n_err++; $display("FAIL wrap_gray63 got=%b want=%b", ptr_o[0], 6'b100000);
        end
      end
      commit();
      if (pushes < 80 && (int'(wb) - m_rbin + 64) % 64 < 3) begin
        wb = wb + 6'd1; pushes++;
      end
    end
  endtask

  task automatic test_random();
    int push_pct, req_pct;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      push_pct = (c % 200 < 100) ? 90 : 30;
      req_pct  = (c % 200 < 100) ? 20 : 80;
      for (int r = 0; r < NR; r++) req[r] = ($urandom_range(0, 99) < req_pct);
      prep();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== expv(i)) begin
          n_err++; $display("FAIL rand_model[%0d] c=%0d got=%h want=%h", i, c, obs(i), expv(i));
        end
      end
      commit();
      if ((int'(wb) - m_rbin + 64) % 64 < 32 && $urandom_range(0, 99) < push_pct) wb = wb + 6'd1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wb = 6'd10; req = 4'b1111;
    prep(); commit();
    prep(); commit();
    prep();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== expv(i)) begin
        n_err++; $display("FAIL mid_before[%0d] got=%h want=%h", i, obs(i), expv(i));
      end
    end
    #1 rd_rst = 1'b1;
    wb = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== {4'b0000, 1'b0, 5'd0, 6'd0, 1'b1, 6'd0, 1'b0, 2'd0}) begin
        n_err++;
        $display("FAIL mid_reset[%0d] got=%h want=%h", i, obs(i), {4'b0000, 1'b0, 5'd0, 6'd0, 1'b1, 6'd0, 1'b0, 2'd0});
      end
    end
    model_reset();
    @(posedge rd_clk); #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (valid_o[i] !== 1'b0) begin
        n_err++; $display("FAIL mid_valid[%0d] got=%b want=0", i, valid_o[i]);
      end
    end
    @(posedge rd_clk); #1 rd_rst = 1'b0;
    wb = 6'd3;
    prep(); commit();
    prep();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (grant_o[i] !== 4'b0001) begin
        n_err++; $display("FAIL mid_first[%0d] got=%b want=0001", i, grant_o[i]);
      end
    end
    commit();
    for (int k = 0; k < 4; k++) begin
      prep();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== expv(i)) begin
          n_err++; $display("FAIL mid_model[%0d] k=%0d got=%h want=%h", i, k, obs(i), expv(i));
        end
      end
      commit();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_pop();
    test_round_robin();
    test_burst();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
